// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared op/state encodings and width defaults for alu_exec
package alu_exec_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier, one partial product per cycle, DATA_W cycles
module alu_mul_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              running;
    logic [DATA_W-1:0] step;

    // product presents the accumulator including the current step, so the
    // final partial product is visible in the same cycle done is raised
    assign step    = acc + (mplier[0] ? mcand : '0);
    assign product = step;
    assign done    = running && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - register-file ALU sequencer: IDLE -> READ -> EXEC -> WB
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB,
    output logic [ADDR_W-1:0] inAddr,
    output logic [DATA_W-1:0] inData,
    output logic              WE,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              carry
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W:0]   alu_res;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    // multiplier loads straight from the read port while READ captures opa/opb
    assign mul_start = (state == ST_READ) && (op_q == OP_MUL);

    alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (outA),
        .b       (outB),
        .done    (mul_done),
        .product (mul_product)
    );

    // top bit carries ADD carry-out / SUB borrow, zero for every other op
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = {1'b0, opa} + {1'b0, opb};
            OP_SUB:  alu_res = {1'b0, opa} - {1'b0, opb};
            OP_AND:  alu_res = {1'b0, opa & opb};
            OP_OR:   alu_res = {1'b0, opa | opb};
            OP_XOR:  alu_res = {1'b0, opa ^ opb};
            OP_SHL:  alu_res = {1'b0, opa << opb[3:0]};
            OP_SHR:  alu_res = {1'b0, opa >> opb[3:0]};
            OP_MUL:  alu_res = {1'b0, mul_product};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADD;
            dst_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            addrA  <= '0;
            addrB  <= '0;
            inAddr <= '0;
            inData <= '0;
            WE     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_e'(op);
                        dst_q <= dst;
                        addrA <= srcA;
                        addrB <= srcB;
                        busy  <= 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    opa   <= outA;
                    opb   <= outB;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q != OP_MUL || mul_done) begin
                        inAddr <= dst_q;
                        inData <= alu_res[DATA_W-1:0];
                        zero   <= (alu_res[DATA_W-1:0] == '0);
                        carry  <= alu_res[DATA_W];
                        WE     <= 1'b1;
                        done   <= 1'b1;
                        state  <= ST_WB;
                    end
                end
                ST_WB: begin
                    WE    <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed-vector bench for alu_exec with a behavioural register file
module tb_alu_exec;
    import alu_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [2:0]  srcA = 3'd0, srcB = 3'd0, dst = 3'd0;
    logic [2:0]  addrA, addrB, inAddr;
    logic [15:0] outA, outB, inData;
    logic        WE, busy, done, zero, carry;

    logic [15:0] regs [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_addr = 3'd0;
    logic [15:0] tb_data = 16'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign outA = regs[addrA];
    assign outB = regs[addrB];

    always @(posedge clk) begin
        if (WE)
            regs[inAddr] <= inData;
        else if (tb_we)
            regs[tb_addr] <= tb_data;
    end

    alu_exec #(.DATA_W(DATA_W_DEF), .ADDR_W(ADDR_W_DEF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .dst(dst),
        .addrA(addrA), .addrB(addrB), .outA(outA), .outB(outB),
        .inAddr(inAddr), .inData(inData), .WE(WE),
        .busy(busy), .done(done), .zero(zero), .carry(carry)
    );

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Issues one command, scrambles the command inputs after acceptance and
    // records what the write port did, relative to the accepting edge (cycle 0).
    task automatic run_cmd(input logic [2:0] o, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [2:0] d, output int we_cyc, output int we_cnt,
                           output int busy_cnt, output logic [15:0] data, output logic [2:0] waddr,
                           output logic z, output logic c, output logic dn);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; srcA = sa; srcB = sb; dst = d;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; srcA = ~sa; srcB = ~sb; dst = ~d;
        cyc = 1; we_cyc = -1; we_cnt = 0; busy_cnt = 0;
        data = 'x; waddr = 'x; z = 1'bx; c = 1'bx; dn = 1'bx;
        while (cyc < 40) begin
            if (busy) busy_cnt++;
            if (WE) begin
                we_cnt++; we_cyc = cyc; data = inData; waddr = inAddr;
                z = zero; c = carry; dn = done;
            end
            if (!busy) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, WE, zero, carry} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_status: got %b expected 00000", {busy, done, WE, zero, carry});
        end
        vectors++;
        if ({addrA, addrB, inAddr, inData} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_ports: got %h expected 0", {addrA, addrB, inAddr, inData});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        set_reg(3'd2, 16'h00FF); set_reg(3'd3, 16'h0001); set_reg(3'd4, 16'h5555);
        run_cmd(OP_ADD, 3'd2, 3'd3, 3'd4, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if (wc !== 3 || wn !== 1) begin
            miscompares++;
            $display("FAIL add_latency: we at cycle %0d count %0d, expected cycle 3 count 1", wc, wn);
        end
        vectors++;
        if ({wa, dt, z, c, dn} !== {3'd4, 16'h0100, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL add_result: addr %0d data %h z %b c %b done %b, expected 4 0100 0 0 1", wa, dt, z, c, dn);
        end
        vectors++;
        if (bn !== 3) begin
            miscompares++;
            $display("FAIL add_busy: got %0d busy cycles expected 3", bn);
        end
        vectors++;
        if (regs[4] !== 16'h0100) begin
            miscompares++;
            $display("FAIL add_regfile: R4 %h expected 0100", regs[4]);
        end
    endtask

    task automatic test_sub_and_carry();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        set_reg(3'd1, 16'h0005); set_reg(3'd2, 16'h0007);
        run_cmd(OP_SUB, 3'd1, 3'd2, 3'd6, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({wc, wa, dt, z, c} !== {32'd3, 3'd6, 16'hFFFE, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_borrow: cyc %0d addr %0d data %h z %b c %b, expected 3 6 FFFE 0 1", wc, wa, dt, z, c);
        end
        set_reg(3'd1, 16'hFFFF); set_reg(3'd2, 16'h0001);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({dt, z, c} !== {16'h0000, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL add_wrap: data %h z %b c %b, expected 0000 1 1", dt, z, c);
        end
        run_cmd(OP_SUB, 3'd2, 3'd2, 3'd3, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({dt, z, c} !== {16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_equal: data %h z %b c %b, expected 0000 1 0", dt, z, c);
        end
    endtask

    task automatic test_logic_shift();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        logic [2:0]  ops [4] = '{OP_AND, OP_OR, OP_SHL, OP_SHR};
        logic [15:0] va  [4] = '{16'hF0F0, 16'hF0F0, 16'h0001, 16'h8000};
        logic [15:0] vb  [4] = '{16'h3C3C, 16'h3C3C, 16'h0013, 16'h000F};
        logic [15:0] exp [4] = '{16'h3030, 16'hFCFC, 16'h0008, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            set_reg(3'd0, va[i]); set_reg(3'd1, vb[i]);
            run_cmd(ops[i], 3'd0, 3'd1, 3'd2, wc, wn, bn, dt, wa, z, c, dn);
            vectors++;
            if ({wc, dt, z, c} !== {32'd3, exp[i], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL logic_op%0d: cyc %0d data %h z %b c %b, expected 3 %h 0 0", ops[i], wc, dt, z, c, exp[i]);
            end
        end
    endtask

    task automatic test_mul();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        set_reg(3'd0, 16'h0012); set_reg(3'd1, 16'h0034);
        run_cmd(OP_MUL, 3'd0, 3'd1, 3'd7, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({wc, wn, bn} !== {32'd18, 32'd1, 32'd18}) begin
            miscompares++;
            $display("FAIL mul_latency: we cyc %0d cnt %0d busy %0d, expected 18 1 18", wc, wn, bn);
        end
        vectors++;
        if ({wa, dt, z, c} !== {3'd7, 16'h03A8, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_result: addr %0d data %h z %b c %b, expected 7 03A8 0 0", wa, dt, z, c);
        end
        set_reg(3'd0, 16'hFFFF);
        run_cmd(OP_MUL, 3'd0, 3'd0, 3'd7, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({wc, dt, c} !== {32'd18, 16'h0001, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_wrap: cyc %0d data %h c %b, expected 18 0001 0", wc, dt, c);
        end
    endtask

    task automatic test_xor_self();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        set_reg(3'd5, 16'h1234);
        run_cmd(OP_XOR, 3'd5, 3'd5, 3'd5, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if ({dt, z, wa} !== {16'h0000, 1'b1, 3'd5}) begin
            miscompares++;
            $display("FAIL xor_self: data %h z %b addr %0d, expected 0000 1 5", dt, z, wa);
        end
        vectors++;
        if (regs[5] !== 16'h0000) begin
            miscompares++;
            $display("FAIL xor_regfile: R5 %h expected 0000", regs[5]);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] we_mask;
        int we_cnt;
        set_reg(3'd2, 16'h00FF); set_reg(3'd3, 16'h0001);
        we_mask = '0; we_cnt = 0;
        @(negedge clk);
        start = 1'b1; op = OP_ADD; srcA = 3'd2; srcB = 3'd3; dst = 3'd4;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            if (e == 9) start = 1'b0;
            if (WE) begin
                we_mask[e + 1] = 1'b1;
                we_cnt++;
            end
        end
        vectors++;
        if (we_cnt !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d WE pulses expected 3", we_cnt);
        end
        vectors++;
        if (we_mask !== 20'h00888) begin
            miscompares++;
            $display("FAIL b2b_cycles: got mask %h expected 00888", we_mask);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        int wc, wn, bn; logic [15:0] dt; logic [2:0] wa; logic z, c, dn;
        logic we_seen;
        set_reg(3'd0, 16'h0012); set_reg(3'd1, 16'h0034); set_reg(3'd7, 16'hBEEF);
        run_cmd(OP_SUB, 3'd0, 3'd1, 3'd6, wc, wn, bn, dt, wa, z, c, dn);
        vectors++;
        if (carry !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: carry %b expected 1", carry);
        end
        we_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; op = OP_MUL; srcA = 3'd0; srcB = 3'd1; dst = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) begin
            we_seen |= WE;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, WE, done, zero, carry} !== 5'b0) begin
            miscompares++;
            $display("FAIL abort_status: busy/we/done/zero/carry %b expected 00000", {busy, WE, done, zero, carry});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            we_seen |= WE | busy;
        end
        vectors++;
        if (we_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_activity: WE/busy seen %b expected 0", we_seen);
        end
        vectors++;
        if (regs[7] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL abort_regfile: R7 %h expected BEEF", regs[7]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        test_reset();
        test_add();
        test_sub_and_carry();
        test_logic_shift();
        test_mul();
        test_xor_self();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
